antares_pipeline_stage: RTL and testbench

Parametrised, elastic pipeline register for the Antares core, generalising the fixed-field ID→EX register into a reusable stage.
- Carries an arbitrary payload split into a control field and a data field. The control field is forced to a bubble value whenever the stage is empty or flushed. The data field is held, never cleared.
- Stall is replaced by a valid/ready handshake with an optional 2-entry skid buffer, so `up_ready` can be fully registered.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and exports occupancy and a stall-cycle counter for performance monitoring.

---
 rtl/antares_pipeline_stage.sv | 134 +++++++++++++
 tb/tb_antares_pipeline_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/antares_pipeline_stage.sv
// Elastic pipeline register with a valid/ready handshake on both sides.
// The control field reads as CTRL_BUBBLE whenever the stage is empty or flushed.
// The data field is only ever overwritten by a newer beat.
// SKID=1 adds a second slot, which keeps up_ready a pure register output.
// SKID=0 keeps a single slot; up_ready then depends combinationally on dn_ready.
// The block also exports occupancy and a saturating stall-cycle counter.
module antares_pipeline_stage #(
  parameter int                    CTRL_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 64,
  parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = '0,
  parameter bit                    SKID        = 1'b1,
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  clr_stats,
  input  logic                  up_valid,
  output logic                  up_ready,
  input  logic [CTRL_WIDTH-1:0] up_ctrl,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  dn_valid,
  input  logic                  dn_ready,
  output logic [CTRL_WIDTH-1:0] dn_ctrl,
  output logic [DATA_WIDTH-1:0] dn_data,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                  main_v;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic [DATA_WIDTH-1:0] main_data;
  logic                  skid_v;
  logic                  acc;
  logic                  pop;
  logic [CNT_WIDTH-1:0]  stall_cnt;

  assign acc = up_valid & up_ready;
  assign pop = main_v & dn_ready;

  generate
    if (SKID) begin : g_skid
      logic                  skid_vq;
      logic [CTRL_WIDTH-1:0] skid_ctrl;
      logic [DATA_WIDTH-1:0] skid_data;

      assign skid_v   = skid_vq;
      assign up_ready = ~skid_vq;

      // Two-slot storage: the skid slot only fills when main is held and a beat still arrives.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          main_v    <= 1'b0;
          main_ctrl <= CTRL_BUBBLE;
          main_data <= '0;
          skid_vq   <= 1'b0;
          skid_ctrl <= CTRL_BUBBLE;
          skid_data <= '0;
        end else if (flush) begin
          main_v    <= 1'b0;
          main_ctrl <= CTRL_BUBBLE;
          skid_vq   <= 1'b0;
          skid_ctrl <= CTRL_BUBBLE;
        end else if (!main_v) begin
          if (acc) begin
            main_v    <= 1'b1;
            main_ctrl <= up_ctrl;
            main_data <= up_data;
          end
        end else if (pop) begin
          if (skid_vq) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            skid_vq   <= 1'b0;
            skid_ctrl <= CTRL_BUBBLE;
          end else if (acc) begin
            main_ctrl <= up_ctrl;
            main_data <= up_data;
          end else begin
            main_v    <= 1'b0;
            main_ctrl <= CTRL_BUBBLE;
          end
        end else if (acc) begin
          skid_vq   <= 1'b1;
          skid_ctrl <= up_ctrl;
          skid_data <= up_data;
        end
      end
    end else begin : g_single
      assign skid_v   = 1'b0;
      assign up_ready = ~main_v | dn_ready;

      // Single slot: a new beat replaces the leaving one in the same cycle.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          main_v    <= 1'b0;
          main_ctrl <= CTRL_BUBBLE;
          main_data <= '0;
        end else if (flush) begin
          main_v    <= 1'b0;
          main_ctrl <= CTRL_BUBBLE;
        end else if (acc) begin
          main_v    <= 1'b1;
          main_ctrl <= up_ctrl;
          main_data <= up_data;
        end else if (pop) begin
          main_v    <= 1'b0;
          main_ctrl <= CTRL_BUBBLE;
        end
      end
    end
  endgenerate

  // Count stalled output cycles; the clear wins over the increment, and the count holds at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_stats) begin
      stall_cnt <= '0;
    end else if (main_v && !dn_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign dn_valid     = main_v;
  assign dn_ctrl      = main_v ? main_ctrl : CTRL_BUBBLE;
  assign dn_data      = main_data;
  assign occupancy    = {1'b0, main_v} + {1'b0, skid_v};
  assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_antares_pipeline_stage.sv
// Bench for antares_pipeline_stage.
// It drives one skid instance (SKID=1, CNT_WIDTH=3) and one single-slot instance (SKID=0) from shared stimulus.
// Each instance is checked against a FIFO-queue reference model.
module tb_antares_pipeline_stage;

  typedef struct packed {
    logic [15:0] c;
    logic [63:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        clr_stats = 1'b0;
  logic        up_valid = 1'b0;
  logic [15:0] up_ctrl = '0;
  logic [63:0] up_data = '0;
  logic        dn_ready = 1'b0;

  logic        sk_up_ready, sk_dn_valid;
  logic [15:0] sk_dn_ctrl;
  logic [63:0] sk_dn_data;
  logic [1:0]  sk_occ;
  logic [2:0]  sk_stall;

  logic        ns_up_ready, ns_dn_valid;
  logic [15:0] ns_dn_ctrl;
  logic [63:0] ns_dn_data;
  logic [1:0]  ns_occ;
  logic [15:0] ns_stall;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // reference model state
  beat_t       q0[$];
  beat_t       q1[$];
  logic [63:0] last0, last1;
  int          cnt0, cnt1;
  bit          r0, r1;

  always #5 clk = ~clk;

  antares_pipeline_stage #(
    .CTRL_WIDTH(16), .DATA_WIDTH(64), .CTRL_BUBBLE(16'h0000), .SKID(1'b1), .CNT_WIDTH(3)
  ) u_sk (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_stats(clr_stats),
    .up_valid(up_valid), .up_ready(sk_up_ready), .up_ctrl(up_ctrl), .up_data(up_data),
    .dn_valid(sk_dn_valid), .dn_ready(dn_ready), .dn_ctrl(sk_dn_ctrl), .dn_data(sk_dn_data),
    .occupancy(sk_occ), .stall_cycles(sk_stall)
  );

  antares_pipeline_stage #(
    .CTRL_WIDTH(16), .DATA_WIDTH(64), .CTRL_BUBBLE(16'h0000), .SKID(1'b0), .CNT_WIDTH(16)
  ) u_ns (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_stats(clr_stats),
    .up_valid(up_valid), .up_ready(ns_up_ready), .up_ctrl(up_ctrl), .up_data(up_data),
    .dn_valid(ns_dn_valid), .dn_ready(dn_ready), .dn_ctrl(ns_dn_ctrl), .dn_data(ns_dn_data),
    .occupancy(ns_occ), .stall_cycles(ns_stall)
  );

  // Model: capacity-2 and capacity-1 FIFOs, updated from the inputs sampled at each edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      last0 = '0;
      last1 = '0;
      cnt0 = 0;
      cnt1 = 0;
    end else begin
      r0 = (q0.size() < 2);
      r1 = (q1.size() == 0) || dn_ready;
      if (clr_stats) cnt0 = 0;
      else if (q0.size() != 0 && !dn_ready && cnt0 < 7) cnt0++;
      if (clr_stats) cnt1 = 0;
      else if (q1.size() != 0 && !dn_ready && cnt1 < 65535) cnt1++;
      if (flush) begin
        q0.delete();
        q1.delete();
      end else begin
        if (q0.size() != 0 && dn_ready) void'(q0.pop_front());
        if (up_valid && r0) q0.push_back('{c: up_ctrl, d: up_data});
        if (q1.size() != 0 && dn_ready) void'(q1.pop_front());
        if (up_valid && r1) q1.push_back('{c: up_ctrl, d: up_data});
      end
      if (q0.size() != 0) last0 = q0[0].d;
      if (q1.size() != 0) last1 = q1[0].d;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [15:0] ec;
    logic [63:0] ed;
    ec = 16'h0000;
    ed = last0;
    if (q0.size() != 0) begin
      ec = q0[0].c;
      ed = q0[0].d;
    end
    chk("sk_dn_valid", 64'(sk_dn_valid), 64'(q0.size() != 0));
    chk("sk_dn_ctrl", 64'(sk_dn_ctrl), 64'(ec));
    chk("sk_dn_data", sk_dn_data, ed);
    chk("sk_up_ready", 64'(sk_up_ready), 64'(q0.size() < 2));
    chk("sk_occupancy", 64'(sk_occ), 64'(q0.size()));
    chk("sk_stall", 64'(sk_stall), 64'(cnt0));
    ec = 16'h0000;
    ed = last1;
    if (q1.size() != 0) begin
      ec = q1[0].c;
      ed = q1[0].d;
    end
    chk("ns_dn_valid", 64'(ns_dn_valid), 64'(q1.size() != 0));
    chk("ns_dn_ctrl", 64'(ns_dn_ctrl), 64'(ec));
    chk("ns_dn_data", ns_dn_data, ed);
    chk("ns_up_ready", 64'(ns_up_ready), 64'((q1.size() == 0) || dn_ready));
    chk("ns_occupancy", 64'(ns_occ), 64'(q1.size()));
    chk("ns_stall", 64'(ns_stall), 64'(cnt1));
  endtask

  task automatic set_in(input logic uv, input logic [63:0] d, input logic dr);
    up_valid  = uv;
    up_data   = d;
    up_ctrl   = {8'hC0, d[7:0]};
    dn_ready  = dr;
    flush     = 1'b0;
    clr_stats = 1'b0;
  endtask

  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nxt;
    bit accepted;

    // reset held two cycles with a valid beat offered
    rst_n = 1'b0;
    up_valid = 1'b1;
    up_ctrl = 16'h00FF;
    up_data = 64'h1234;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_in(1'b0, 64'h0, 1'b1);
    #1;
    chk("rst_sk_dn_valid", 64'(sk_dn_valid), 64'd0);
    chk("rst_sk_dn_ctrl", 64'(sk_dn_ctrl), 64'h0);
    chk("rst_sk_dn_data", sk_dn_data, 64'h0);
    chk("rst_sk_up_ready", 64'(sk_up_ready), 64'd1);
    chk("rst_sk_occ", 64'(sk_occ), 64'd0);
    chk("rst_ns_dn_valid", 64'(ns_dn_valid), 64'd0);
    chk("rst_ns_up_ready", 64'(ns_up_ready), 64'd1);
    chk("rst_ns_stall", 64'(ns_stall), 64'd0);
    tick();

    // streaming 1..8 with dn_ready high
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, 64'(i), 1'b1);
      tick();
      chk("stream_data", sk_dn_data, 64'(i));
    end
    set_in(1'b0, 64'h0, 1'b1);
    repeat (2) tick();

    // back-pressure: 4 stalled cycles after beat 2 appears
    nxt = 1;
    for (int c = 0; c < 14; c++) begin
      set_in(nxt <= 6, 64'(nxt), !(c >= 2 && c <= 5));
      if (c == 3) begin
        chk("bp_occ", 64'(sk_occ), 64'd2);
        chk("bp_up_ready", 64'(sk_up_ready), 64'd0);
        chk("bp_head", sk_dn_data, 64'd2);
      end
      if (c == 6) chk("bp_stall", 64'(sk_stall), 64'd4);
      accepted = (nxt <= 6) && (q0.size() < 2);
      tick();
      if (accepted) nxt++;
    end

    // flush while the skid instance is full, with 0xAA offered during the flush
    set_in(1'b1, 64'h11, 1'b0);
    tick();
    set_in(1'b1, 64'h22, 1'b0);
    tick();
    chk("fl_pre_occ", 64'(sk_occ), 64'd2);
    set_in(1'b1, 64'hAA, 1'b0);
    flush = 1'b1;
    tick();
    set_in(1'b0, 64'h0, 1'b0);
    #1;
    chk("fl_dn_valid", 64'(sk_dn_valid), 64'd0);
    chk("fl_dn_ctrl", 64'(sk_dn_ctrl), 64'h0);
    chk("fl_occ", 64'(sk_occ), 64'd0);
    chk("fl_up_ready", 64'(sk_up_ready), 64'd1);
    chk("fl_ns_dn_valid", 64'(ns_dn_valid), 64'd0);
    set_in(1'b0, 64'h0, 1'b1);
    repeat (3) tick();

    // single-slot instance: combinational dn_ready -> up_ready
    set_in(1'b1, 64'h33, 1'b0);
    tick();
    set_in(1'b1, 64'h44, 1'b0);
    #1;
    chk("ns_ready_low", 64'(ns_up_ready), 64'd0);
    dn_ready = 1'b1;
    #1;
    chk("ns_ready_high", 64'(ns_up_ready), 64'd1);
    tick();
    chk("ns_took_beat", ns_dn_data, 64'h44);
    chk("ns_took_valid", 64'(ns_dn_valid), 64'd1);

    // stall counter saturation and clear on the 3-bit instance
    set_in(1'b0, 64'h0, 1'b0);
    repeat (10) tick();
    chk("cnt_saturate", 64'(sk_stall), 64'd7);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("cnt_cleared", 64'(sk_stall), 64'd0);
    tick();
    chk("cnt_resume", 64'(sk_stall), 64'd1);

    // randomized traffic with occasional flush, clear and a mid-run reset
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      up_ctrl   = 16'($urandom);
      flush     = ($urandom_range(0, 19) == 0);
      clr_stats = ($urandom_range(0, 29) == 0);
      rst_n     = (i != 200);
      tick();
    end
    rst_n = 1'b1;
    set_in(1'b0, 64'h0, 1'b1);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
